// File: rtl/blkasm_pkg.sv
// Shared constants, FSM state type and input word layout for the block assembler controller.
package blkasm_pkg;

    localparam int NPKT  = 16;
    localparam int PKT_W = 29;
    localparam int POS_W = $clog2(NPKT);

    typedef enum logic [1:0] {
        COLLECT,
        LAST,
        FULL
    } state_t;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic [PKT_W-1:0] pkt;
    } pkt_word_t;

endpackage

// File: rtl/blkasm_to_cntr.sv
// Inactivity counter that flags a stalled partial block after TO_CYC idle cycles.
module blkasm_to_cntr #(
    parameter int TO_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic reload,
    output logic expire
);

    localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    logic [CW-1:0] cnt;

    assign expire = run && (cnt == CW'(TO_CYC - 1));

    // Any accept, an expiry, or leaving the partial-block condition restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run || reload || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/blkasm_ctrl.sv
// Packet block assembler sequencing controller; define BLKASM_CTRL_TIMEOUT_EN to
// compile in the partial-block inactivity timeout.
module blkasm_ctrl
   import blkasm_pkg::*;
#(
   parameter int TO_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [POS_W+PKT_W-1:0] data,
   input  logic                   avl,
   output logic                   in_rdy,
   output logic                   wr_en,
   output logic [POS_W-1:0]       wr_pos,
   output logic [PKT_W-1:0]       wr_pkt,
   output logic                   blk_vld,
   input  logic                   blk_ack,
   output logic [NPKT-1:0]        rcv_map,
   output logic [POS_W:0]         rcv_cnt,
   output logic                   dup_err,
   output logic                   ovf_err,
   output logic                   to_err
);

   state_t    state;
   state_t    stateNxt;
   pkt_word_t word;
   logic      accept;
   logic      dup;
   logic      ovf;
   logic      expire;

   assign word   = pkt_word_t'(data);
   assign accept = avl && (state == COLLECT) && !rcv_map[word.pos];
   assign dup    = avl && (state == COLLECT) &&  rcv_map[word.pos];
   assign ovf    = avl && (state != COLLECT);

`ifdef BLKASM_CTRL_TIMEOUT_EN
   logic toHit;

   blkasm_to_cntr #(
      .TO_CYC (TO_CYC)
   ) u_to_cntr (
      .clk    (clk),
      .reset  (reset),
      .run    ((state == COLLECT) && (rcv_cnt != '0)),
      .reload (accept),
      .expire (toHit)
   );

   // A packet arriving on the expiry cycle keeps the block alive.
   assign expire = toHit && !accept;

   // Timeout error pulse is registered one cycle after the expiry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_err <= 1'b0;
      end else begin
         to_err <= expire;
      end
   end
`else
   assign expire = 1'b0;
   assign to_err = 1'b0;
`endif

   // State register, returns to COLLECT on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= COLLECT;
      end else begin
         state <= stateNxt;
      end
   end

   // Next-state logic plus the state-decoded handshake outputs.
   always_comb begin
      stateNxt = state;
      in_rdy   = 1'b0;
      blk_vld  = 1'b0;
      case (state)
         COLLECT: begin
            in_rdy = 1'b1;
            if (accept && (rcv_cnt == (POS_W+1)'(NPKT - 1))) begin
               stateNxt = LAST;
            end
         end
         LAST: begin
            stateNxt = FULL;
         end
         FULL: begin
            blk_vld = 1'b1;
            if (blk_ack) begin
               stateNxt = COLLECT;
            end
         end
         default: begin
            stateNxt = COLLECT;
         end
      endcase
   end

   // Write strobe, slot bookkeeping and error pulses all settle one edge after the request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en   <= 1'b0;
         wr_pos  <= '0;
         wr_pkt  <= '0;
         rcv_map <= '0;
         rcv_cnt <= '0;
         dup_err <= 1'b0;
         ovf_err <= 1'b0;
      end else begin
         wr_en   <= accept;
         dup_err <= dup;
         ovf_err <= ovf;
         if (accept) begin
            wr_pos            <= word.pos;
            wr_pkt            <= word.pkt;
            rcv_map[word.pos] <= 1'b1;
            rcv_cnt           <= rcv_cnt + 1'b1;
         end else if (((state == FULL) && blk_ack) || expire) begin
            rcv_map <= '0;
            rcv_cnt <= '0;
         end
      end
   end

endmodule

// File: doc/blkasm_ctrl.md
# blkasm_ctrl

Sequencing controller for the 16-slot packet block assembler datapath. It accepts position-tagged packets, filters duplicates and out-of-window traffic, and issues one write strobe per new slot to the assembler's block storage. It raises a block-valid handshake to the downstream consumer once all slots are filled. An optional inactivity timeout aborts stalled partial blocks.

## Interface
- NPKT, 16, packets per block (power of two)
- PKT_W, 29, packet payload width
- POS_W, $clog2(NPKT) = 4, position field width (derived, not overridden)
- TO_CYC, 1024, inactivity timeout in cycles (only used with timeout compiled in)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- data  in  POS_W+PKT_W  {position[POS_W+PKT_W-1:PKT_W], packet[PKT_W-1:0]}
- avl  in  1  data valid this cycle
- in_rdy  out  1  controller accepting packets (combinational from state)
- wr_en  out  1  storage write strobe, registered
- wr_pos  out  POS_W  slot index for write, registered
- wr_pkt  out  PKT_W  payload for write, registered
- blk_vld  out  1  complete block present in storage
- blk_ack  in  1  consumer has taken block
- rcv_map  out  NPKT  slots filled in current block
- rcv_cnt  out  POS_W+1  number of filled slots, 0..NPKT
- dup_err  out  1  one-cycle pulse: duplicate position dropped
- ovf_err  out  1  one-cycle pulse: avl while in_rdy low, packet dropped
- to_err  out  1  one-cycle pulse: partial block aborted by timeout

## Operation
- States: COLLECT, LAST, FULL. Reset state COLLECT.
- Reset values: in_rdy=1, wr_en=0, wr_pos=0, wr_pkt=0, blk_vld=0, rcv_map=0, rcv_cnt=0, all err pulses 0, timeout counter 0.
- in_rdy = (state==COLLECT).
- COLLECT, avl=1, rcv_map[pos]=0: accept; set rcv_map[pos], rcv_cnt+1; next cycle wr_en=1 with wr_pos/wr_pkt. If rcv_cnt becomes NPKT -> LAST.
- COLLECT, avl=1, rcv_map[pos]=1: drop; no write; dup_err=1 next cycle; map/count unchanged.
- avl=1 in LAST or FULL: drop; ovf_err=1 next cycle.
- LAST: one cycle while final write is in flight; -> FULL unconditionally.
- FULL: blk_vld=1; hold until blk_ack=1 sampled; on that edge rcv_map=0, rcv_cnt=0, -> COLLECT. blk_ack outside FULL ignored.
- rcv_cnt never exceeds NPKT; no wrap.
- Reset mid-block: everything returns to reset values immediately; a pending wr_en is cancelled.

## Timing
- Packet accepted at edge k -> wr_en high in cycle k..k+1, storage writes at edge k+1; rcv_map/rcv_cnt reflect packet after edge k.
- Final packet at edge k: LAST after k, FULL after k+1; blk_vld high from edge k+1 (storage write complete at same edge).
- Minimum block turnaround: NPKT accept cycles + LAST + 1 FULL cycle with immediate ack = NPKT+2 cycles.
- Error pulses exactly one cycle wide, one cycle after the offending avl.
- Back-to-back accepts allowed every cycle in COLLECT.

## Configuration
- BLKASM_CTRL_TIMEOUT_EN defined: counter runs in COLLECT while rcv_cnt>0; reloads to 0 on every accepted packet; when it reaches TO_CYC-1 with no accept that cycle, rcv_map and rcv_cnt clear, to_err pulses next cycle, state stays COLLECT. Accept in the same cycle as expiry wins (packet taken, counter reloads). Counter held at 0 in LAST/FULL.
- Undefined: no counter logic; to_err tied 0; partial blocks wait indefinitely.

## Structure
- Shared package blkasm_pkg: NPKT, PKT_W, POS_W constants, state enum type (COLLECT/LAST/FULL), packed struct for {pos, pkt} input word.
- One sub-module: blkasm_to_cntr (timeout counter, instantiated only under the macro).
- Storage itself is outside this block.

## Test plan
- 16 packets, positions 15..0 one per cycle, then blk_ack one cycle after blk_vld -> 16 wr_en pulses with matching wr_pos/wr_pkt, blk_vld rises 2 cycles after last avl, rcv_cnt 16 -> 0 after ack.
- Position 5 sent twice (payloads 0x0AAAAAAA, 0x15555555) -> second dropped, dup_err one pulse, storage holds 0x0AAAAAAA, rcv_cnt=1.
- Fill block, hold blk_ack=0 for 10 cycles while driving avl -> in_rdy=0, ovf_err pulses each cycle, no wr_en, blk_vld stays 1.
- Timeout (macro on, TO_CYC=8): 3 packets then idle -> to_err pulse after 8 idle cycles, rcv_map=0; packet arriving exactly on expiry cycle -> accepted, no to_err.
- Reset asserted after 7 packets with wr_en pending -> all outputs at reset values immediately, next 16 packets form a fresh block.
- blk_ack pulsed in COLLECT with 4 packets held -> ignored, rcv_cnt stays 4.
